// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multicycle MIPS core.
// The master side is the controller; the slave side is the datapath.
interface multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic [2:0]         ALUOp;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSrc;
    logic               IorD;
    logic               IRWrite;
    logic               MemWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               PCEn;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  opcode, funct, zero,
        output ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite,
        output MemWrite, RegDst, MemtoReg, RegWrite, PCEn, state_o
    );

    modport slave (
        output opcode, funct, zero,
        input  ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite,
        input  MemWrite, RegDst, MemtoReg, RegWrite, PCEn, state_o
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style main controller for the multicycle MIPS datapath.
// Sequences lw, sw, R-type, beq, addi and j through fetch/decode/execute.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH    = 'd0,
        DECODE   = 'd1,
        MEMADR   = 'd2,
        MEMRD    = 'd3,
        MEMWB    = 'd4,
        MEMWR    = 'd5,
        EXECUTE  = 'd6,
        ALUWB    = 'd7,
        BRANCH   = 'd8,
        ADDIEXEC = 'd9,
        ADDIWB   = 'd10,
        JUMP     = 'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state;
    state_t next;
    logic   pc_write;
    logic   branch;
    logic   ir_write;
    logic   mem_write;
    logic   reg_write;
    logic   funct_ok;

    always_comb begin
        funct_ok = 1'b0;
        case (bus.funct)
            6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010: funct_ok = 1'b1;
            default:              funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next;
    end

    always_comb begin
        next         = FETCH;
        bus.ALUOp    = 3'b010;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.PCSrc    = 2'b00;
        bus.IorD     = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        ir_write     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        case (state)
            FETCH: begin
                bus.ALUSrcB = 2'b01;
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                next        = DECODE;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = funct_ok ? EXECUTE : FETCH;
                    OP_BEQ:       next = BRANCH;
                    OP_ADDI:      next = ADDIEXEC;
                    OP_J:         next = JUMP;
                    default:      next = FETCH;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                next        = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.IorD = 1'b1;
                next     = MEMWB;
            end
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                reg_write    = 1'b1;
            end
            MEMWR: begin
                bus.IorD  = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                bus.ALUSrcA = 1'b1;
                case (bus.funct)
                    6'b100010: bus.ALUOp = 3'b110;
                    6'b100100: bus.ALUOp = 3'b000;
                    6'b100101: bus.ALUOp = 3'b001;
                    6'b101010: bus.ALUOp = 3'b111;
                    default:   bus.ALUOp = 3'b010;
                endcase
                next = ALUWB;
            end
            ALUWB: begin
                bus.RegDst = 1'b1;
                reg_write  = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 3'b110;
                bus.PCSrc   = 2'b01;
                branch      = 1'b1;
            end
            ADDIEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                next        = ADDIWB;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                bus.PCSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: next = FETCH;
        endcase
    end

    // Reset shows FETCH selects but must never let a write escape.
    assign bus.IRWrite  = ir_write & ~rst;
    assign bus.MemWrite = mem_write & ~rst;
    assign bus.RegWrite = reg_write & ~rst;
    assign bus.PCEn     = (pc_write | (branch & bus.zero)) & ~rst;
    assign bus.state_o  = state;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for the multicycle MIPS main controller.
// Walks each instruction class and checks states and control outputs.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   rw_pulses = 0;
    int   rw_before;

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.STATE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.RegWrite) rw_pulses <= rw_pulses + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        bus.opcode = 6'b0;
        bus.funct  = 6'b0;
        bus.zero   = 1'b0;
        nxt(); nxt();
        check("rst_state", bus.state_o, 0);
        check("rst_irw", bus.IRWrite, 0);
        check("rst_pcen", bus.PCEn, 0);
        check("rst_aluop", bus.ALUOp, 3'b010);
        check("rst_srcb", bus.ALUSrcB, 2'b01);
        rst = 1'b0;
        #1;
        check("fetch_irw", bus.IRWrite, 1);
        check("fetch_pcen", bus.PCEn, 1);

        // lw: 0,1,2,3,4,0 with a single register write
        bus.opcode = 6'b100011;
        rw_before = rw_pulses;
        nxt(); check("lw_dec", bus.state_o, 1);
        check("lw_dec_srcb", bus.ALUSrcB, 2'b11);
        nxt(); check("lw_adr", bus.state_o, 2);
        check("lw_adr_srcb", bus.ALUSrcB, 2'b10);
        nxt(); check("lw_rd", bus.state_o, 3);
        check("lw_rd_iord", bus.IorD, 1);
        check("lw_rd_rw", bus.RegWrite, 0);
        nxt(); check("lw_wb", bus.state_o, 4);
        check("lw_wb_rw", bus.RegWrite, 1);
        check("lw_wb_m2r", bus.MemtoReg, 1);
        check("lw_wb_dst", bus.RegDst, 0);
        nxt(); check("lw_done", bus.state_o, 0);
        check("lw_rw_cnt", rw_pulses - rw_before, 1);

        // reset during MEMRD aborts the lw
        nxt(); nxt(); nxt();
        check("ab_rd", bus.state_o, 3);
        rst = 1'b1;
        #1;
        check("ab_state", bus.state_o, 0);
        for (int i = 0; i < 3; i++) begin
            check("ab_irw", bus.IRWrite, 0);
            check("ab_pcen", bus.PCEn, 0);
            check("ab_rw", bus.RegWrite, 0);
            check("ab_mw", bus.MemWrite, 0);
            nxt();
        end
        rst = 1'b0;
        #1;
        check("ab_rel_st", bus.state_o, 0);
        check("ab_rel_irw", bus.IRWrite, 1);
        check("ab_rel_pcen", bus.PCEn, 1);

        // R-type sub then slt
        bus.opcode = 6'b000000;
        bus.funct  = 6'b100010;
        nxt(); check("sub_dec", bus.state_o, 1);
        nxt(); check("sub_ex", bus.state_o, 6);
        check("sub_op", bus.ALUOp, 3'b110);
        check("sub_srca", bus.ALUSrcA, 1);
        check("sub_srcb", bus.ALUSrcB, 2'b00);
        nxt(); check("sub_wb", bus.state_o, 7);
        check("sub_dst", bus.RegDst, 1);
        check("sub_rw", bus.RegWrite, 1);
        nxt(); check("sub_done", bus.state_o, 0);
        bus.funct = 6'b101010;
        nxt(); check("slt_dec", bus.state_o, 1);
        nxt(); check("slt_op", bus.ALUOp, 3'b111);
        bus.funct = 6'b100101;
        #1 check("or_op", bus.ALUOp, 3'b001);
        bus.funct = 6'b100100;
        #1 check("and_op", bus.ALUOp, 3'b000);
        bus.funct = 6'b101010;
        nxt(); check("slt_wb", bus.state_o, 7);
        nxt(); check("slt_done", bus.state_o, 0);

        // beq taken, then not taken
        bus.opcode = 6'b000100;
        bus.zero   = 1'b1;
        nxt(); check("beq1_dec", bus.state_o, 1);
        nxt(); check("beq1_br", bus.state_o, 8);
        check("beq1_op", bus.ALUOp, 3'b110);
        check("beq1_src", bus.PCSrc, 2'b01);
        check("beq1_pcen", bus.PCEn, 1);
        nxt(); check("beq1_done", bus.state_o, 0);
        bus.zero = 1'b0;
        nxt(); check("beq0_dec", bus.state_o, 1);
        check("beq0_dec_pcen", bus.PCEn, 0);
        nxt(); check("beq0_br", bus.state_o, 8);
        check("beq0_pcen", bus.PCEn, 0);
        nxt(); check("beq0_done", bus.state_o, 0);

        // illegal opcode and illegal funct
        bus.opcode = 6'b111111;
        nxt(); check("ill_dec", bus.state_o, 1);
        check("ill_rw", bus.RegWrite, 0);
        check("ill_mw", bus.MemWrite, 0);
        nxt(); check("ill_done", bus.state_o, 0);
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        nxt(); check("ilf_dec", bus.state_o, 1);
        nxt(); check("ilf_done", bus.state_o, 0);

        // sw, addi, j back-to-back
        bus.opcode = 6'b101011;
        nxt(); check("sw_dec", bus.state_o, 1);
        check("sw_dec_mw", bus.MemWrite, 0);
        nxt(); check("sw_adr", bus.state_o, 2);
        check("sw_adr_mw", bus.MemWrite, 0);
        nxt(); check("sw_wr", bus.state_o, 5);
        check("sw_wr_mw", bus.MemWrite, 1);
        check("sw_wr_iord", bus.IorD, 1);
        check("sw_wr_rw", bus.RegWrite, 0);
        nxt(); check("sw_done", bus.state_o, 0);
        check("sw_fetch_mw", bus.MemWrite, 0);
        bus.opcode = 6'b001000;
        nxt(); check("addi_dec", bus.state_o, 1);
        nxt(); check("addi_ex", bus.state_o, 9);
        check("addi_srcb", bus.ALUSrcB, 2'b10);
        check("addi_op", bus.ALUOp, 3'b010);
        nxt(); check("addi_wb", bus.state_o, 10);
        check("addi_rw", bus.RegWrite, 1);
        check("addi_dst", bus.RegDst, 0);
        check("addi_m2r", bus.MemtoReg, 0);
        nxt(); check("addi_done", bus.state_o, 0);
        bus.opcode = 6'b000010;
        nxt(); check("j_dec", bus.state_o, 1);
        nxt(); check("j_jmp", bus.state_o, 11);
        check("j_src", bus.PCSrc, 2'b10);
        check("j_pcen", bus.PCEn, 1);
        check("j_irw", bus.IRWrite, 0);
        nxt(); check("j_done", bus.state_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main controller for the multicycle MIPS datapath. Drives the 3-bit ALUOp consumed directly by the ALU, plus every mux select and write enable.
- Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps; the ALU zero flag returns here for beq resolution.
- Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi, j.

Parameters:
- STATE_W, 4, width of state register and debug state port.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  instr[31:26] from instruction register (stable after FETCH)
- funct  input  6  instr[5:0] from instruction register
- zero  input  1  ALU zero flag
- ALUOp  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- ALUSrcA  output  1  0=PC, 1=register A
- ALUSrcB  output  2  00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2
- PCSrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
- IorD  output  1  memory address: 0=PC, 1=ALUOut
- IRWrite  output  1  instruction register load
- MemWrite  output  1  data memory write
- RegDst  output  1  0=rt, 1=rd
- MemtoReg  output  1  0=ALUOut, 1=memory data
- RegWrite  output  1  register file write
- PCEn  output  1  PC load = PCWrite | (Branch & zero)
- state_o  output  STATE_W  current state, for verification

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and return to FETCH on the next edge.
- Reset: asynchronous; state=FETCH immediately. While rst=1, IRWrite, PCEn, MemWrite and RegWrite are forced 0; selects show FETCH values (ALUOp=010, ALUSrcB=01, others 0). Reset asserted mid-instruction aborts it with no further writes. First FETCH cycle is the first rising edge after rst falls.
- Outputs are pure functions of state, except EXECUTE ALUOp (depends on funct) and PCEn (depends on zero). Any output not listed for a state is 0; ALUOp defaults to 010.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, IRWrite=1, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=010 (branch target precompute). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 with legal funct -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - illegal opcode, or R-type with illegal funct -> FETCH (no architectural write)
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=010. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: IorD=1 -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1 -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUOp from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Next: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=110, PCSrc=01, Branch=1 (PCEn=zero, combinational, same cycle) -> FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=010 -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- No outputs are ever X or Z; ALUOp is only ever one of the five legal codes.

Test Plan:
- Reset: rst=1 for 3 cycles during MEMRD of a lw -> state_o=0 immediately; IRWrite=PCEn=RegWrite=MemWrite=0 while rst=1; after release, FETCH with IRWrite=1, PCEn=1.
- lw (opcode 100011) -> state_o 0,1,2,3,4,0; MEMWB cycle shows RegWrite=1, MemtoReg=1, RegDst=0; exactly one RegWrite pulse.
- R-type, funct 100010 then 101010 -> EXECUTE ALUOp=110 then 111; ALUWB RegDst=1, RegWrite=1; 4 cycles each.
- beq with zero=1, then zero=0 -> BRANCH ALUOp=110, PCSrc=01, PCEn=1 then PCEn=0; return to FETCH after 3 cycles in both cases.
- Illegal opcode 111111, and R-type funct 000000 -> DECODE->FETCH; no RegWrite/MemWrite; sequence 0,1,0.
- sw, addi, j back-to-back -> states 0,1,2,5 / 0,1,9,10 / 0,1,11; MemWrite=1 only in MEMWR; JUMP PCSrc=10, PCEn=1.
